// File: rtl/pacman_pkg.sv
// Shared types and helpers for the ghost scheduler: ghost/phase encodings,
// the phase-length lookup and the combo bonus constants.
package pacman_pkg;

    typedef enum logic [2:0] {
        GM_HOUSE   = 3'd0,
        GM_SCATTER = 3'd1,
        GM_CHASE   = 3'd2,
        GM_FRIGHT  = 3'd3,
        GM_EATEN   = 3'd4
    } ghost_mode_t;

    typedef enum logic [2:0] {
        PH_IDLE     = 3'd0,
        PH_SCATTER0 = 3'd1,
        PH_CHASE1   = 3'd2,
        PH_SCATTER2 = 3'd3,
        PH_CHASE3   = 3'd4,
        PH_SCATTER4 = 3'd5,
        PH_CHASE5   = 3'd6
    } phase_t;

    localparam logic [9:0] BONUS_BASE = 10'd200;
    localparam logic [1:0] COMBO_MAX  = 2'd2;

    // The final chase phase runs forever, so its length is reported as 0.
    function automatic logic [10:0] phase_len(input phase_t p,
                                              input logic [10:0] scatter,
                                              input logic [10:0] chase);
        case (p)
            PH_SCATTER0, PH_SCATTER2: return scatter;
            PH_SCATTER4:              return 11'((32'(scatter) * 32'd5) / 32'd7);
            PH_CHASE1, PH_CHASE3:     return chase;
            default:                  return 11'd0;
        endcase
    endfunction

    function automatic ghost_mode_t phase_mode(input phase_t p);
        case (p)
            PH_CHASE1, PH_CHASE3, PH_CHASE5: return GM_CHASE;
            default:                         return GM_SCATTER;
        endcase
    endfunction

endpackage

// File: rtl/ghost_slot.sv
// Per-ghost mode register with its release (count-up) / eaten (count-down)
// counter and the raw hit qualification used by the top-level arbiter.
module ghost_slot
    import pacman_pkg::*;
#(
    parameter logic [10:0] RELEASE_DELAY = 11'd0,
    parameter logic [10:0] EATEN_FRAMES  = 11'd180
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        restart,
    input  logic        life_down,
    input  logic        qual_tick,
    input  logic        fruit_eaten,
    input  logic        hit,
    input  logic        grant,
    input  logic        fright_next,
    input  ghost_mode_t phase_mode_next,
    output ghost_mode_t mode,
    output logic        hittable
);

    logic [10:0] cnt;

    assign hittable = hit && (mode == GM_FRIGHT);

    // Released and recovering ghosts look at next-cycle phase/fright state so
    // they land in the mode that is current when their change becomes visible.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mode <= GM_HOUSE;
            cnt  <= '0;
        end else if (restart || life_down) begin
            mode <= GM_HOUSE;
            cnt  <= '0;
        end else if (grant) begin
            mode <= GM_EATEN;
            cnt  <= EATEN_FRAMES;
        end else begin
            case (mode)
                GM_HOUSE: begin
                    if (qual_tick) begin
                        if (cnt >= RELEASE_DELAY) begin
                            mode <= phase_mode_next;
                            cnt  <= '0;
                        end else begin
                            cnt <= cnt + 11'd1;
                        end
                    end
                end
                GM_SCATTER, GM_CHASE: mode <= fruit_eaten ? GM_FRIGHT : phase_mode_next;
                GM_FRIGHT: begin
                    if (!fright_next) mode <= phase_mode_next;
                end
                GM_EATEN: begin
                    if (qual_tick) begin
                        if (cnt <= 11'd1) begin
                            cnt  <= '0;
                            mode <= fright_next ? GM_FRIGHT : phase_mode_next;
                        end else begin
                            cnt <= cnt - 11'd1;
                        end
                    end
                end
                default: mode <= GM_HOUSE;
            endcase
        end
    end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Ghost behaviour sequencer: scatter/chase phase timetable, staggered release,
// fright overlay, eaten recovery and bonus handshake. GHOST_FRIGHT_FLASH_EN enables fright_flash.
module ghost_mode_scheduler
    import pacman_pkg::*;
#(
    parameter logic [10:0] SCATTER_FRAMES = 11'd420,
    parameter logic [10:0] CHASE_FRAMES   = 11'd1200,
    parameter logic [10:0] FRIGHT_FRAMES  = 11'd360,
    parameter logic [10:0] FLASH_FRAMES   = 11'd120,
    parameter logic [10:0] RELEASE_GAP    = 11'd120,
    parameter logic [10:0] EATEN_FRAMES   = 11'd180
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       run_en,
    input  logic       restart,
    input  logic       lifeDown,
    input  logic       fruit_eaten,
    input  logic [2:0] ghost_hit,
    output logic [8:0] ghost_mode,
    output logic       fright_active,
    output logic       fright_flash,
    output logic [9:0] bonus_pts,
    output logic       bonus_valid,
    input  logic       bonus_ack
);

    if (FLASH_FRAMES > FRIGHT_FRAMES) begin : g_flash_check
        $error("FLASH_FRAMES must not exceed FRIGHT_FRAMES");
    end

    logic        qual_tick;
    logic        phase_step;
    logic        phase_adv;
    phase_t      phase;
    phase_t      phase_succ;
    logic [10:0] phase_cnt;
    ghost_mode_t phase_mode_next;
    logic        fright_next;
    logic [10:0] fright_cnt;
    logic [10:0] fright_cnt_next;
    logic [2:0]  hittable;
    logic [2:0]  grant;
    logic [1:0]  combo;
    ghost_mode_t slot_mode [3];

    assign qual_tick  = frame_tick & run_en;
    assign phase_step = qual_tick & ~fright_active;
    assign phase_succ = phase_t'(phase + 3'd1);
    assign phase_adv  = phase_step &&
                        ((phase == PH_IDLE) || ((phase != PH_CHASE5) && (phase_cnt <= 11'd1)));
    assign phase_mode_next = phase_mode(phase_adv ? phase_succ : phase);

    // The first qualified tick already counts as the first scatter frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase     <= PH_IDLE;
            phase_cnt <= '0;
        end else if (restart) begin
            phase     <= PH_IDLE;
            phase_cnt <= '0;
        end else if (phase_adv) begin
            phase     <= phase_succ;
            phase_cnt <= (phase == PH_IDLE) ? SCATTER_FRAMES - 11'd1
                                            : phase_len(phase_succ, SCATTER_FRAMES, CHASE_FRAMES);
        end else if (phase_step && (phase_cnt != 11'd0)) begin
            phase_cnt <= phase_cnt - 11'd1;
        end
    end

    always_comb begin
        fright_next     = fright_active;
        fright_cnt_next = fright_cnt;
        if (restart || lifeDown) begin
            fright_next     = 1'b0;
            fright_cnt_next = '0;
        end else if (fruit_eaten) begin
            fright_next     = 1'b1;
            fright_cnt_next = FRIGHT_FRAMES;
        end else if (fright_active && qual_tick) begin
            if (fright_cnt <= 11'd1) begin
                fright_next     = 1'b0;
                fright_cnt_next = '0;
            end else begin
                fright_cnt_next = fright_cnt - 11'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fright_active <= 1'b0;
            fright_cnt    <= '0;
        end else begin
            fright_active <= fright_next;
            fright_cnt    <= fright_cnt_next;
        end
    end

`ifdef GHOST_FRIGHT_FLASH_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) fright_flash <= 1'b0;
        else          fright_flash <= fright_next && (fright_cnt_next <= FLASH_FRAMES);
    end
`else
    assign fright_flash = 1'b0;
`endif

    // Only one ghost can be eaten per cycle, and never while a bonus is unacknowledged.
    always_comb begin
        grant = 3'b000;
        if (!restart && !lifeDown && !fruit_eaten && !bonus_valid) begin
            if (hittable[0])      grant = 3'b001;
            else if (hittable[1]) grant = 3'b010;
            else if (hittable[2]) grant = 3'b100;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bonus_valid <= 1'b0;
            bonus_pts   <= '0;
            combo       <= '0;
        end else if (restart) begin
            bonus_valid <= 1'b0;
            bonus_pts   <= '0;
            combo       <= '0;
        end else begin
            if (bonus_valid && bonus_ack) bonus_valid <= 1'b0;
            if (fruit_eaten && !lifeDown) begin
                combo <= '0;
            end else if (grant != 3'b000) begin
                bonus_valid <= 1'b1;
                bonus_pts   <= BONUS_BASE << combo;
                combo       <= (combo == COMBO_MAX) ? combo : combo + 2'd1;
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_slot
        ghost_slot #(
            .RELEASE_DELAY(11'(32'(RELEASE_GAP) * g)),
            .EATEN_FRAMES (EATEN_FRAMES)
        ) u_slot (
            .Clk            (Clk),
            .Reset_n        (Reset_n),
            .restart        (restart),
            .life_down      (lifeDown),
            .qual_tick      (qual_tick),
            .fruit_eaten    (fruit_eaten),
            .hit            (ghost_hit[g]),
            .grant          (grant[g]),
            .fright_next    (fright_next),
            .phase_mode_next(phase_mode_next),
            .mode           (slot_mode[g]),
            .hittable       (hittable[g])
        );
        assign ghost_mode[3*g +: 3] = slot_mode[g];
    end

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Directed bench for ghost_mode_scheduler: a vector table walked in order plus
// hand-written sequences for fright retrigger-at-expiry and eaten recovery.
module tb_ghost_mode_scheduler;

    localparam int H = 0, S = 1, C = 2, F = 3, E = 4;
`ifdef GHOST_FRIGHT_FLASH_EN
    localparam bit FLASH_ON = 1'b1;
`else
    localparam bit FLASH_ON = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_tick, run_en, restart, lifeDown, fruit_eaten, bonus_ack;
    logic [2:0] ghost_hit;
    logic [8:0] ghost_mode;
    logic       fright_active, fright_flash, bonus_valid;
    logic [9:0] bonus_pts;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int       ticks;
        bit       run;
        bit       fruit;
        bit [2:0] hit;
        bit       ack;
        bit       life;
        bit       rst;
        bit [8:0] mode;
        bit       fright;
        bit       flash;
        bit       valid;
        bit [9:0] pts;
    } vec_t;

    vec_t vq[$];

    always #5 Clk = ~Clk;

    ghost_mode_scheduler dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_tick   (frame_tick),
        .run_en       (run_en),
        .restart      (restart),
        .lifeDown     (lifeDown),
        .fruit_eaten  (fruit_eaten),
        .ghost_hit    (ghost_hit),
        .ghost_mode   (ghost_mode),
        .fright_active(fright_active),
        .fright_flash (fright_flash),
        .bonus_pts    (bonus_pts),
        .bonus_valid  (bonus_valid),
        .bonus_ack    (bonus_ack)
    );

    function automatic bit [8:0] m(input int r, input int b, input int o);
        return {3'(o), 3'(b), 3'(r)};
    endfunction

    function automatic void add(input int t, input bit run, input bit fr, input bit [2:0] h,
                                input bit ak, input bit lf, input bit rs, input bit [8:0] md,
                                input bit fa, input bit fl, input bit v, input bit [9:0] p);
        vec_t x;
        x.ticks = t; x.run = run; x.fruit = fr; x.hit = h; x.ack = ak; x.life = lf; x.rst = rs;
        x.mode = md; x.fright = fa; x.flash = fl; x.valid = v; x.pts = p;
        vq.push_back(x);
    endfunction

    task automatic applyStimulus(input bit tick, input bit run, input bit fr, input bit [2:0] h,
                                 input bit ak, input bit lf, input bit rs);
        frame_tick  = tick;
        run_en      = run;
        fruit_eaten = fr;
        ghost_hit   = h;
        bonus_ack   = ak;
        lifeDown    = lf;
        restart     = rs;
        @(posedge Clk);
        #1;
        frame_tick  = 1'b0;
        fruit_eaten = 1'b0;
        ghost_hit   = 3'b000;
        bonus_ack   = 1'b0;
        lifeDown    = 1'b0;
        restart     = 1'b0;
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    initial begin
        int n;
        Reset_n = 1'b0; frame_tick = 1'b0; run_en = 1'b1; restart = 1'b0; lifeDown = 1'b0;
        fruit_eaten = 1'b0; ghost_hit = 3'b000; bonus_ack = 1'b0;
        #12;
        checkOutput("reset mode",   int'(ghost_mode),    0);
        checkOutput("reset fright", int'(fright_active), 0);
        checkOutput("reset flash",  int'(fright_flash),  0);
        checkOutput("reset valid",  int'(bonus_valid),   0);
        checkOutput("reset pts",    int'(bonus_pts),     0);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // ticks run fruit hit ack life rst | mode fright flash valid pts
        add(1,   1, 0, 3'b000, 0, 0, 0, m(S, H, H), 0, 0, 0, 0);
        add(119, 1, 0, 3'b000, 0, 0, 0, m(S, H, H), 0, 0, 0, 0);
        add(1,   1, 0, 3'b000, 0, 0, 0, m(S, S, H), 0, 0, 0, 0);
        add(120, 1, 0, 3'b000, 0, 0, 0, m(S, S, S), 0, 0, 0, 0);
        add(178, 1, 0, 3'b000, 0, 0, 0, m(S, S, S), 0, 0, 0, 0);
        add(1,   1, 0, 3'b000, 0, 0, 0, m(C, C, C), 0, 0, 0, 0);
        add(0,   1, 0, 3'b111, 0, 0, 0, m(C, C, C), 0, 0, 0, 0);
        add(0,   1, 0, 3'b000, 0, 0, 1, m(H, H, H), 0, 0, 0, 0);
        add(241, 1, 0, 3'b000, 0, 0, 0, m(S, S, S), 0, 0, 0, 0);
        add(0,   1, 1, 3'b000, 0, 0, 0, m(F, F, F), 1, 0, 0, 0);
        add(0,   1, 0, 3'b011, 0, 0, 0, m(E, F, F), 1, 0, 1, 200);
        add(0,   1, 0, 3'b010, 0, 0, 0, m(E, F, F), 1, 0, 1, 200);
        add(0,   1, 0, 3'b010, 1, 0, 0, m(E, F, F), 1, 0, 0, 200);
        add(0,   1, 0, 3'b010, 0, 0, 0, m(E, E, F), 1, 0, 1, 400);
        add(0,   1, 0, 3'b000, 1, 0, 0, m(E, E, F), 1, 0, 0, 400);
        add(0,   1, 0, 3'b100, 0, 0, 0, m(E, E, E), 1, 0, 1, 800);
        add(0,   1, 0, 3'b000, 1, 0, 0, m(E, E, E), 1, 0, 0, 800);
        add(0,   1, 0, 3'b111, 0, 0, 0, m(E, E, E), 1, 0, 0, 800);
        add(179, 1, 0, 3'b000, 0, 0, 0, m(E, E, E), 1, 0, 0, 800);
        add(1,   1, 0, 3'b000, 0, 0, 0, m(F, F, F), 1, 0, 0, 800);
        add(59,  1, 0, 3'b000, 0, 0, 0, m(F, F, F), 1, 0, 0, 800);
        add(1,   1, 0, 3'b000, 0, 0, 0, m(F, F, F), 1, 1, 0, 800);
        add(119, 1, 0, 3'b000, 0, 0, 0, m(F, F, F), 1, 1, 0, 800);
        add(1,   1, 0, 3'b000, 0, 0, 0, m(S, S, S), 0, 0, 0, 800);
        add(178, 1, 0, 3'b000, 0, 0, 0, m(S, S, S), 0, 0, 0, 800);
        add(1,   1, 0, 3'b000, 0, 0, 0, m(C, C, C), 0, 0, 0, 800);
        add(100, 1, 0, 3'b000, 0, 0, 0, m(C, C, C), 0, 0, 0, 800);
        add(0,   1, 1, 3'b000, 0, 0, 0, m(F, F, F), 1, 0, 0, 800);
        add(10,  1, 0, 3'b000, 0, 0, 0, m(F, F, F), 1, 0, 0, 800);
        add(0,   1, 0, 3'b001, 0, 0, 0, m(E, F, F), 1, 0, 1, 200);
        add(0,   1, 0, 3'b000, 0, 1, 0, m(H, H, H), 0, 0, 1, 200);
        add(0,   1, 0, 3'b000, 1, 0, 0, m(H, H, H), 0, 0, 0, 200);
        add(1,   1, 0, 3'b000, 0, 0, 0, m(C, H, H), 0, 0, 0, 200);
        add(120, 1, 0, 3'b000, 0, 0, 0, m(C, C, H), 0, 0, 0, 200);
        add(978, 1, 0, 3'b000, 0, 0, 0, m(C, C, C), 0, 0, 0, 200);
        add(1,   1, 0, 3'b000, 0, 0, 0, m(S, S, S), 0, 0, 0, 200);
        add(0,   1, 1, 3'b000, 0, 0, 0, m(F, F, F), 1, 0, 0, 200);
        add(0,   1, 0, 3'b001, 0, 0, 0, m(E, F, F), 1, 0, 1, 200);
        add(0,   1, 0, 3'b000, 0, 0, 1, m(H, H, H), 0, 0, 0, 0);
        add(5,   0, 0, 3'b000, 0, 0, 0, m(H, H, H), 0, 0, 0, 0);
        add(1,   1, 0, 3'b000, 0, 0, 0, m(S, H, H), 0, 0, 0, 0);

        foreach (vq[k]) begin
            for (int i = 0; i < vq[k].ticks; i++)
                applyStimulus(1'b1, vq[k].run, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
            if (vq[k].fruit || (vq[k].hit != 3'b000) || vq[k].ack || vq[k].life || vq[k].rst)
                applyStimulus(1'b0, 1'b1, vq[k].fruit, vq[k].hit, vq[k].ack, vq[k].life, vq[k].rst);
            checkOutput($sformatf("v%0d mode", k),   int'(ghost_mode),    int'(vq[k].mode));
            checkOutput($sformatf("v%0d fright", k), int'(fright_active), int'(vq[k].fright));
            checkOutput($sformatf("v%0d flash", k),  int'(fright_flash),  int'(vq[k].flash & FLASH_ON));
            checkOutput($sformatf("v%0d valid", k),  int'(bonus_valid),   int'(vq[k].valid));
            checkOutput($sformatf("v%0d pts", k),    int'(bonus_pts),     int'(vq[k].pts));
        end

        // Retrigger on the very tick the fright timer would expire.
        applyStimulus(1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        checkOutput("fruit red", int'(ghost_mode[2:0]), F);
        runTicks(359);
        checkOutput("pre-expiry fright", int'(fright_active), 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        checkOutput("retrigger red", int'(ghost_mode[2:0]), F);
        checkOutput("retrigger fright", int'(fright_active), 1);
        runTicks(1);
        checkOutput("after retrigger fright", int'(fright_active), 1);

        // Eaten ghost recovers into FRIGHT while the overlay is still running.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
        checkOutput("eat red mode", int'(ghost_mode[2:0]), E);
        checkOutput("eat red pts", int'(bonus_pts), 200);
        n = 0;
        while ((ghost_mode[2:0] == 3'(E)) && (n < 200)) begin
            runTicks(1);
            n++;
        end
        checkOutput("eaten duration", n, 180);
        checkOutput("eaten return mode", int'(ghost_mode[2:0]), F);
        checkOutput("eaten return fright", int'(fright_active), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ghost_mode_scheduler.md
# ghost_mode_scheduler

Sequences the behaviour mode of the three ghosts (red, blue, orange) over the course of a game. It releases ghosts from the house on a staggered schedule and runs the global scatter/chase phase timetable. It overlays the frightened period triggered by fruit pickups and handles eaten-ghost recovery. It also issues bonus-score requests to the score register path, alongside the game state controller, and advances only on frame ticks while the game is running.

## Interface
- SCATTER_FRAMES, 420, frames per scatter phase (phases 0, 2); phase 4 uses SCATTER_FRAMES*5/7, truncated
- CHASE_FRAMES, 1200, frames per chase phase (phases 1, 3)
- FRIGHT_FRAMES, 360, length of frightened overlay
- FLASH_FRAMES, 120, final frames of fright with flash asserted; must be ≤ FRIGHT_FRAMES
- RELEASE_GAP, 120, frames between successive ghost releases
- EATEN_FRAMES, 180, frames an eaten ghost spends returning before re-entering
- All parameters must fit in 11 bits
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- run_en  in  1  high while the game controller is in Run; timers freeze when low
- restart  in  1  one-cycle pulse; full return to reset state
- lifeDown  in  1  one-cycle pulse; ghosts return to house
- fruit_eaten  in  1  one-cycle pulse; starts or retriggers fright
- ghost_hit  in  3  per-ghost contact with Pac-Man, level; bit0 red, bit1 blue, bit2 orange
- ghost_mode  out  9  3 bits per ghost: 0 HOUSE, 1 SCATTER, 2 CHASE, 3 FRIGHT, 4 EATEN
- fright_active  out  1  fright overlay running
- fright_flash  out  1  last FLASH_FRAMES of fright
- bonus_pts  out  10  bonus points requested
- bonus_valid  out  1  request pending; held until acknowledged
- bonus_ack  in  1  score path accepted bonus_pts

## Operation
- Reset and restart: all ghosts HOUSE; phase index 0; all counters 0; fright_active, fright_flash, bonus_valid 0; bonus_pts 0; combo 0.
- Phase FSM: IDLE → SCATTER(0) on the first frame_tick with run_en. Phases alternate SCATTER/CHASE for indices 0–4; index 5 is CHASE indefinitely. The phase counter decrements per qualified tick; at 0 the phase advances.
- Release: red leaves HOUSE on the first qualified tick. Blue leaves RELEASE_GAP ticks later, orange 2*RELEASE_GAP ticks later. A released ghost takes the current global phase mode (SCATTER/CHASE).
- Fright: fruit_eaten forces every SCATTER/CHASE ghost to FRIGHT. It loads the fright counter with FRIGHT_FRAMES and clears combo; HOUSE and EATEN ghosts are unaffected. The phase counter pauses while fright_active. At fright expiry, FRIGHT ghosts revert to the current phase mode.
- Retrigger: fruit_eaten during fright reloads the counter and clears combo.
- Eating: a ghost_hit bit on a FRIGHT ghost is accepted only when bonus_valid=0, and only the lowest-index bit is accepted per cycle. On acceptance the ghost goes to EATEN with its own counter loaded with EATEN_FRAMES. bonus_pts = 200 << combo, and combo increments, saturating at 2. At counter 0 the ghost re-enters the current phase mode, or FRIGHT if fright is still active.
- ghost_hit on a SCATTER/CHASE ghost is ignored here; the game controller owns life loss.
- lifeDown: all ghosts HOUSE, release schedule restarts, fright cancelled; phase index and counter are retained. A pending bonus request stays valid.
- Handshake: bonus_valid stays high with bonus_pts stable until a cycle with bonus_ack=1, then drops the next cycle.

## Timing
- All outputs are registered. Effects of a qualified frame_tick (tick & run_en) appear one cycle later.
- fruit_eaten, restart and lifeDown take effect on the next edge regardless of frame_tick and run_en.
- Priority in the same cycle: restart > lifeDown > fruit_eaten > ghost_hit > counter expiries.
- When fruit_eaten and fright expiry coincide, the retrigger wins and ghosts stay FRIGHT.
- When bonus_ack and a new accepted hit coincide, the current request completes. The new hit is not accepted that cycle because bonus_valid is still 1.
- Counters are 11 bits and never wrap: they hold at 0.

## Configuration
- GHOST_FRIGHT_FLASH_EN defined: fright_flash is high when fright_active and fright counter ≤ FLASH_FRAMES.
- Undefined: fright_flash is tied 0 and the comparison logic is omitted.

## Structure
- pacman_pkg holds the ghost_mode_t enum, the phase_t enum, the phase-length lookup function and the combo score constants.
- Sub-module ghost_slot, instantiated 3×, contains the per-ghost mode register, release/eaten counter and hit acceptance. The top level contains the phase FSM, the fright timer, the hit priority logic and the bonus handshake.

## Test plan
- Reset, then hold run_en with 1200 ticks → red SCATTER at tick 1, blue at tick 121, orange at tick 241; all ghosts CHASE after tick 420.
- fruit_eaten at tick 100 → all released ghosts FRIGHT for 360 ticks; phase switch delayed to tick 780; with the macro, flash asserts from remaining=120.
- During fright, hit red, then blue, then orange, acking each → bonus_pts 200, 400, 800; each eaten ghost reverts after 180 ticks.
- ghost_hit=3'b011 with no ack → only red EATEN and bonus 200 pending; blue is accepted only after ack.
- lifeDown during fright in CHASE phase 1 → all HOUSE, fright off, phase 1 resumes with its remaining count.
- restart mid-game → all outputs return to reset values on the next cycle.
